// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default fixed-point format and Q1.14 constants.
package fft_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned FRAC_BITS  = 14;

    // Q1.14 reference points.
    localparam int Q_ONE     = 16384;
    localparam int Q_HALF    = 8192;
    localparam int Q_QUARTER = 4096;

    // One complex sample in the datapath.
    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } complex_t;

endpackage

// File: rtl/z_mult_scale.sv
// Rescales a wide signed product sum back to DATA_WIDTH: floor shift by FRAC_BITS,
// then wrap (default) or clamp when Z_MULT_SAT_EN is defined.
module z_mult_scale
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = fft_pkg::DATA_WIDTH,
    parameter int unsigned FRAC_BITS  = fft_pkg::FRAC_BITS
) (
    input  logic signed [2*DATA_WIDTH:0]   sum,
    output logic signed [DATA_WIDTH-1:0]   result_c
);

    localparam int unsigned SUM_W = 2 * DATA_WIDTH + 1;

`ifdef Z_MULT_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [SUM_W-1:0] shifted;

    // Floor shift, then clamp to the representable output range.
    always_comb begin
        shifted  = sum >>> FRAC_BITS;
        result_c = DATA_WIDTH'(shifted);
        if (shifted > SAT_MAX) begin
            result_c = DATA_WIDTH'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            result_c = DATA_WIDTH'(SAT_MIN);
        end
    end
`else
    // Floor shift, keep the low bits (two's-complement wrap).
    assign result_c = DATA_WIDTH'(sum >>> FRAC_BITS);
`endif

endmodule

// File: rtl/z_multiplier.sv
// Two-stage pipelined signed fixed-point complex multiplier (FFT twiddle multiply).
// Optional output saturation: define Z_MULT_SAT_EN.
module z_multiplier
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = fft_pkg::DATA_WIDTH,
    parameter int unsigned FRAC_BITS  = fft_pkg::FRAC_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] Ar,
    input  logic signed [DATA_WIDTH-1:0] Ai,
    input  logic signed [DATA_WIDTH-1:0] Br,
    input  logic signed [DATA_WIDTH-1:0] Bi,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] Rout,
    output logic signed [DATA_WIDTH-1:0] Iout
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned SUM_W  = 2 * DATA_WIDTH + 1;

    logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic                     valid_s1;
    logic signed [SUM_W-1:0]  sum_r, sum_i;
    logic signed [DATA_WIDTH-1:0] rout_c, iout_c;

    // Stage 1: four full-width signed partial products, valid tracked alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_rr     <= '0;
            p_ii     <= '0;
            p_ri     <= '0;
            p_ir     <= '0;
            valid_s1 <= 1'b0;
        end else begin
            p_rr     <= PROD_W'(Ar) * PROD_W'(Br);
            p_ii     <= PROD_W'(Ai) * PROD_W'(Bi);
            p_ri     <= PROD_W'(Ar) * PROD_W'(Bi);
            p_ir     <= PROD_W'(Ai) * PROD_W'(Br);
            valid_s1 <= in_valid;
        end
    end

    // One extra bit so the difference/sum of two products cannot overflow.
    assign sum_r = SUM_W'(p_rr) - SUM_W'(p_ii);
    assign sum_i = SUM_W'(p_ri) + SUM_W'(p_ir);

    z_mult_scale #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_scale_re (
        .sum      (sum_r),
        .result_c (rout_c)
    );

    z_mult_scale #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_scale_im (
        .sum      (sum_i),
        .result_c (iout_c)
    );

    // Stage 2: register the rescaled results; data updates every cycle, valid qualifies it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Rout      <= '0;
            Iout      <= '0;
            out_valid <= 1'b0;
        end else begin
            Rout      <= rout_c;
            Iout      <= iout_c;
            out_valid <= valid_s1;
        end
    end

endmodule

// File: tb/tb_z_multiplier.sv
// Scoreboard bench for z_multiplier: directed Q1.14 cases, mid-stream reset, random stream.
module tb_z_multiplier;

    localparam int unsigned W = fft_pkg::DATA_WIDTH;
    localparam int unsigned F = fft_pkg::FRAC_BITS;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic signed [W-1:0] Ar, Ai, Br, Bi;
    logic                out_valid;
    logic signed [W-1:0] Rout, Iout;

    z_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .Ar        (Ar),
        .Ai        (Ai),
        .Br        (Br),
        .Bi        (Bi),
        .out_valid (out_valid),
        .Rout      (Rout),
        .Iout      (Iout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  v;
        int    r;
        int    i;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic, floor shift, then wrap or clamp.
    function automatic int scale_ref(input longint s);
        longint q;
        logic signed [W-1:0] t;
        q = s >>> F;
`ifdef Z_MULT_SAT_EN
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
`endif
        t = W'(q);
        return int'(t);
    endfunction

    // One clock: compare the result due from two cycles ago, then drive and record new inputs.
    task automatic cycle(input string tag, input logic v,
                         input int ar, input int ai, input int br, input int bi,
                         input int er, input int ei);
        exp_t e;
        @(negedge clk);
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            check({e.tag, ".valid"}, int'(out_valid), int'(e.v));
            if (e.v) begin
                check({e.tag, ".rout"}, int'(Rout), e.r);
                check({e.tag, ".iout"}, int'(Iout), e.i);
            end
        end
        in_valid = v;
        Ar = W'(ar);
        Ai = W'(ai);
        Br = W'(br);
        Bi = W'(bi);
        e.v = v; e.r = er; e.i = ei; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic cycle_model(input string tag, input logic v,
                               input int ar, input int ai, input int br, input int bi);
        longint sr, si;
        sr = longint'(ar) * longint'(br) - longint'(ai) * longint'(bi);
        si = longint'(ar) * longint'(bi) + longint'(ai) * longint'(br);
        cycle(tag, v, ar, ai, br, bi, scale_ref(sr), scale_ref(si));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle("idle", 1'b0, 0, 0, 0, 0, 0, 0);
    endtask

    int sat_i;
    int big_r;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        Ar = '0; Ai = '0; Br = '0; Bi = '0;
`ifdef Z_MULT_SAT_EN
        sat_i = 32767;
        big_r = 32767;
`else
        sat_i = -32768;
        big_r = 0;
`endif
        repeat (3) @(negedge clk);
        check("reset.valid", int'(out_valid), 0);
        check("reset.rout", int'(Rout), 0);
        check("reset.iout", int'(Iout), 0);
        rst = 1'b0;

        // Directed cases, back to back.
        cycle("one_sq",    1'b1, fft_pkg::Q_ONE, 0, fft_pkg::Q_ONE, 0, fft_pkg::Q_ONE, 0);
        cycle("half_sq",   1'b1, fft_pkg::Q_HALF, 0, fft_pkg::Q_HALF, 0, fft_pkg::Q_QUARTER, 0);
        cycle("times_mj",  1'b1, 8192, 0, 0, -16384, 0, -8192);
        cycle("neg_half",  1'b1, -16384, 0, 8192, 0, -8192, 0);
        cycle("neg_one",   1'b1, -16384, 0, 16384, 0, -16384, 0);
        cycle("cancel",    1'b1, 16384, 16384, 8192, 8192, 0, 16384);
        cycle("conj",      1'b1, 8192, 8192, 8192, -8192, 8192, 0);
        cycle("near_max",  1'b1, 14746, 14746, 14746, 14746, 0, 26543);
        cycle("ovf_i",     1'b1, 16384, 16384, 16384, 16384, 0, sat_i);
        cycle("floor_neg", 1'b1, -1, 0, 1, 0, -1, 0);
        cycle("min_sq",    1'b1, -32768, 0, -32768, 0, big_r, 0);
        idle(3);

        // Reset in the middle of a stream: outputs clear without waiting for a clock.
        cycle("pre_rst0", 1'b1, 16384, 0, 16384, 0, 16384, 0);
        cycle("pre_rst1", 1'b1, 8192, 0, 8192, 0, 4096, 0);
        cycle("pre_rst2", 1'b1, 8192, 8192, 8192, -8192, 8192, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("mid_rst.valid", int'(out_valid), 0);
        check("mid_rst.rout", int'(Rout), 0);
        check("mid_rst.iout", int'(Iout), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        idle(2);
        cycle("post_rst", 1'b1, -16384, 0, 8192, 0, -8192, 0);
        idle(3);

        // Random stream with a gap every third cycle.
        for (int k = 0; k < 12; k++) begin
            cycle_model($sformatf("rnd%0d", k), (k % 3) != 2,
                        int'($signed(W'($urandom))), int'($signed(W'($urandom))),
                        int'($signed(W'($urandom))), int'($signed(W'($urandom))));
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
